mont_residue: RTL and testbench

Computes the Montgomery residue constant R² mod M = 2^(64·length) mod M for a multi-word modulus M stored in word-addressed memory, one 32-bit word per address, least-significant word at address 0. It sits directly upstream of `montprod`. Its result stream is written into the operand memory that `montprod` reads, so operands can be brought into Montgomery form (A·R² → A·R) before exponentiation. Uses the same word-memory conventions as `montprod`: 8-bit word address, 32-bit data, 1-cycle synchronous read latency.

---
 rtl/modexp_pkg.sv | 21 ++
 rtl/residue_mem.sv | 22 ++
 rtl/mont_residue.sv | 185 ++++++++++++++++++
 tb/tb_mont_residue.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared constants and FSM encoding for the modular-exponentiation word datapath.
// Word memories are 32 bits wide with 8-bit word addresses.
package modexp_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;
  localparam int NWORDS = 256;
  localparam int ITER_W = 15;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    COMPARE,
    SUB,
    NEXT,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/residue_mem.sv
// Single-port scratch RAM with a 1-cycle synchronous read.
// A read in the same cycle as a write returns the old contents.
module residue_mem
  import modexp_pkg::*;
#(
  parameter int DEPTH = NWORDS
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mont_residue.sv
// Computes R^2 mod M = 2^(64*L) mod M by 64*L modular doublings of a scratch value,
// then streams the L result words out in ascending order.
module mont_residue
  import modexp_pkg::*;
#(
  parameter int NWORDS = modexp_pkg::NWORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              calculate,
  output logic              ready,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] opm_addr,
  input  logic [WORD_W-1:0] opm_data,
  output logic [ADDR_W-1:0] result_addr,
  output logic [WORD_W-1:0] result_data,
  output logic              result_we
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              ph_q, ph_d;
  logic              cb_q, cb_d;
  logic [ADDR_W-1:0] opm_addr_q;
  logic              res_we_q, res_we_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [WORD_W-1:0] res_data_q, res_data_d;

  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              rd_m;
  logic              last;
  logic [WORD_W:0]   sub_w;
  logic [ITER_W-1:0] cnt_inc;

  residue_mem #(.DEPTH(NWORDS)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (idx_q),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign last     = (idx_q == len_q - 8'd1);
  assign sub_w    = {1'b0, mem_rdata} - {1'b0, opm_data} - {{WORD_W{1'b0}}, cb_q};
  assign cnt_inc  = cnt_q + ITER_W'(1);
  assign opm_addr = rd_m ? idx_q : opm_addr_q;
  assign ready    = (state_q == IDLE) || (state_q == DONE);

  assign result_we   = res_we_q;
  assign result_addr = res_addr_q;
  assign result_data = res_data_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    cb_d       = cb_q;
    res_we_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    rd_m       = 1'b0;
    case (state_q)
      IDLE: begin
        if (calculate) begin
          len_d = length;
          cnt_d = '0;
          idx_d = '0;
          ph_d  = 1'b0;
          if (length != '0) state_d = INIT;
        end
      end
      INIT: begin
        mem_we    = 1'b1;
        mem_wdata = (idx_q == '0) ? 32'd1 : 32'd0;
        if (last) begin
          state_d = SHIFT;
          idx_d   = '0;
          cb_d    = 1'b0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      SHIFT: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          mem_we    = 1'b1;
          mem_wdata = {mem_rdata[WORD_W-2:0], cb_q};
          cb_d      = mem_rdata[WORD_W-1];
          if (!last) begin
            idx_d = idx_q + 8'd1;
          end else if (mem_rdata[WORD_W-1]) begin
            // Carry out of the top word means S >= 2^(32L) > M: subtract without comparing.
            state_d = SUB;
            idx_d   = '0;
            cb_d    = 1'b0;
          end else begin
            state_d = COMPARE;
            idx_d   = len_q - 8'd1;
          end
        end
      end
      COMPARE: begin
        rd_m = 1'b1;
        ph_d = ~ph_q;
        if (ph_q) begin
          if (mem_rdata < opm_data) begin
            state_d = NEXT;
          end else if (mem_rdata > opm_data || idx_q == '0) begin
            state_d = SUB;
            idx_d   = '0;
            cb_d    = 1'b0;
          end else begin
            idx_d = idx_q - 8'd1;
          end
        end
      end
      SUB: begin
        rd_m = 1'b1;
        ph_d = ~ph_q;
        if (ph_q) begin
          mem_we    = 1'b1;
          mem_wdata = sub_w[WORD_W-1:0];
          cb_d      = sub_w[WORD_W];
          if (last) state_d = NEXT;
          else      idx_d   = idx_q + 8'd1;
        end
      end
      NEXT: begin
        cnt_d = cnt_inc;
        idx_d = '0;
        ph_d  = 1'b0;
        cb_d  = 1'b0;
        if (cnt_inc == {1'b0, len_q, 6'b0}) state_d = OUTPUT;
        else                                state_d = SHIFT;
      end
      OUTPUT: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          res_we_d   = 1'b1;
          res_addr_d = idx_q;
          res_data_d = mem_rdata;
          if (last) state_d = DONE;
          else      idx_d   = idx_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      cb_q       <= 1'b0;
      opm_addr_q <= '0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      cb_q       <= cb_d;
      opm_addr_q <= opm_addr;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
    end
  end

endmodule

// File: tb/tb_mont_residue.sv
// Scoreboard bench for mont_residue: expected result words are queued at start,
// a forked monitor pops and compares each result_we strobe.
module tb_mont_residue;
  import modexp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        calculate;
  logic        ready;
  logic [7:0]  length;
  logic [7:0]  opm_addr;
  logic [31:0] opm_data;
  logic [7:0]  result_addr;
  logic [31:0] result_data;
  logic        result_we;

  logic [31:0] mmem [0:255];

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   wr_total = 0;

  mont_residue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .calculate   (calculate),
    .ready       (ready),
    .length      (length),
    .opm_addr    (opm_addr),
    .opm_data    (opm_data),
    .result_addr (result_addr),
    .result_data (result_data),
    .result_we   (result_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) opm_data <= mmem[opm_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [287:0] ref_res(input int L, input logic [287:0] m);
    logic [287:0] r;
    r = 288'd1;
    for (int k = 0; k < 64 * L; k++) begin
      r = r << 1;
      if (r >= m) r = r - m;
    end
    return r;
  endfunction

  task automatic run(input int L, input logic [287:0] m, input logic [287:0] expv, input bit poke);
    int base;
    int bound;
    int cyc;
    for (int i = 0; i < L; i++) mmem[i] = m[32*i +: 32];
    for (int i = 0; i < L; i++) exp_q.push_back('{a: 8'(i), d: expv[32*i +: 32]});
    base  = wr_total;
    bound = L + 64 * L * (6 * L + 1) + 2 * L + 2 + 4;
    @(posedge clk); #1;
    length    = 8'(L);
    calculate = 1'b1;
    @(posedge clk); #1;
    calculate = 1'b0;
    length    = 8'd7;
    if (L > 0) chk("ready_fall", {31'b0, ready}, 32'd0);
    else       chk("ready_len0", {31'b0, ready}, 32'd1);
    cyc = 0;
    while (!ready && cyc < bound) begin
      calculate = (poke && cyc == 3);
      length    = (poke && cyc == 3) ? 8'd5 : 8'd7;
      @(posedge clk); #1;
      cyc++;
    end
    calculate = 1'b0;
    chk("ready_in_bound", {31'b0, ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("write_count", 32'(wr_total - base), 32'(L));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int           ls [4] = '{1, 2, 4, 8};
    logic [287:0] m;
    int           cyc;

    reset_n   = 1'b0;
    calculate = 1'b0;
    length    = 8'd0;
    for (int i = 0; i < 256; i++) mmem[i] = 32'd0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (result_we === 1'b1) begin
          wr_total++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_we: got addr %h data %h expected no write", result_addr, result_data);
          end else begin
            e = exp_q.pop_front();
            chk("result_addr", {24'b0, result_addr}, {24'b0, e.a});
            chk("result_data", result_data, e.d);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_we", {31'b0, result_we}, 32'd0);
    chk("rst_raddr", {24'b0, result_addr}, 32'd0);
    chk("rst_rdata", result_data, 32'd0);
    chk("rst_opm_addr", {24'b0, opm_addr}, 32'd0);
    reset_n = 1'b1;

    run(1, 288'h13,       288'h11, 1'b0);
    run(1, 288'h11,       288'h1,  1'b0);
    run(1, 288'h0b,       288'h5,  1'b0);
    run(1, 288'h7fffffff, 288'h4,  1'b0);
    run(2, 288'h1_00000001, 288'h1, 1'b0);
    run(0, 288'h0,        288'h0,  1'b0);
    run(1, 288'h13,       288'h11, 1'b1);

    // Abort a run while it is subtracting, then prove a clean restart.
    mmem[0] = 32'h13;
    @(posedge clk); #1;
    length    = 8'd1;
    calculate = 1'b1;
    @(posedge clk); #1;
    calculate = 1'b0;
    cyc = 0;
    while (dut.state_q != SUB && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_sub", {31'b0, dut.state_q == SUB}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midrst_ready", {31'b0, ready}, 32'd1);
    chk("midrst_we", {31'b0, result_we}, 32'd0);
    chk("midrst_raddr", {24'b0, result_addr}, 32'd0);
    chk("midrst_rdata", result_data, 32'd0);
    run(1, 288'h13, 288'h11, 1'b0);

    foreach (ls[j]) begin
      m = '0;
      for (int i = 0; i < ls[j]; i++) m[32*i +: 32] = $urandom;
      m[0] = 1'b1;
      if (m == 288'd1) m = 288'd3;
      run(ls[j], m, ref_res(ls[j], m), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
